// File: rtl/gj_pkg.sv
// Shared definitions for the Gauss-Jordan inversion sequencer.
// Holds the default matrix order and index widths, the FSM state encoding
// and the datapath command opcodes.
package gj_pkg;

    localparam int unsigned N_DEF  = 5;
    localparam int unsigned RW_DEF = 3;
    localparam int unsigned CW_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_NORM  = 3'd2,
        ST_ELIM  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_NORM = 2'b01,
        OP_ELIM = 2'b10
    } op_t;

endpackage

// File: rtl/gj_idx_cnt.sv
// Row/column index counter for the sequencer.
// Ports: clk/rst; clr zeroes both indices; load_norm points at (pivot, 0);
// load_elim points at the first non-pivot row, column 0; step advances the
// column and, in elim mode, wraps it and moves to the next non-pivot row.
// col_last_c / row_last_c flag the final column and final elimination row.
module gj_idx_cnt
    import gj_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned RW = RW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load_norm,
    input  logic          load_elim,
    input  logic          step,
    input  logic          elim,
    input  logic [RW-1:0] pivot,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          col_last_c,
    output logic          row_last_c
);

    logic [RW-1:0] first_row_c;
    logic [RW-1:0] row_inc_c;
    logic [RW-1:0] row_next_c;

    // Elimination visits every row except the pivot row.
    always_comb begin
        first_row_c = (pivot == RW'(0)) ? RW'(1) : RW'(0);
        row_last_c  = (pivot == RW'(N - 1)) ? (row == RW'(N - 2)) : (row == RW'(N - 1));
        col_last_c  = (col == CW'(2 * N - 1));
        row_inc_c   = row + RW'(1);
        row_next_c  = (row_inc_c == pivot) ? row + RW'(2) : row_inc_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (load_norm) begin
            row <= pivot;
            col <= '0;
        end else if (load_elim) begin
            row <= first_row_c;
            col <= '0;
        end else if (step) begin
            if (elim && col_last_c) begin
                row <= row_next_c;
                col <= '0;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gj_sequencer.sv
// Gauss-Jordan inversion command sequencer.
// Walks pivots k = 0..N-1 over an N x 2N augmented matrix: one CHECK cycle
// for a zero pivot, 2N NORM commands on row k, then 2N ELIM commands on each
// other row. Commands use a valid/ready handshake and hold while stalled.
// Ports: start/abort control, pivot_zero from the datapath, cmd_ready in;
// cmd_valid/op/pivot/row/col command bus, busy, done pulse, sticky err out.
module gj_sequencer
    import gj_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned RW = RW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          pivot_zero,
    input  logic          cmd_ready,
    output logic          cmd_valid,
    output logic [1:0]    cmd_op,
    output logic [RW-1:0] cmd_pivot,
    output logic [RW-1:0] cmd_row,
    output logic [CW-1:0] cmd_col,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state;
    logic [RW-1:0] k;
    logic          hs_c;
    logic          col_last_c;
    logic          row_last_c;
    logic          clr_c;
    logic          load_norm_c;
    logic          load_elim_c;
    logic          step_c;
    logic          elim_c;

    assign cmd_pivot = k;

    // Counter control derived from the current state and handshake.
    always_comb begin
        hs_c        = cmd_valid & cmd_ready;
        elim_c      = (state == ST_ELIM);
        clr_c       = (state == ST_IDLE) & start & ~abort;
        load_norm_c = (state == ST_CHECK) & ~pivot_zero;
        load_elim_c = (state == ST_NORM) & hs_c & col_last_c;
        step_c      = hs_c & (((state == ST_NORM) & ~col_last_c) |
                              ((state == ST_ELIM) & ~(col_last_c & row_last_c)));
    end

    gj_idx_cnt #(
        .N  (N),
        .RW (RW),
        .CW (CW)
    ) u_idx_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr_c),
        .load_norm  (load_norm_c),
        .load_elim  (load_elim_c),
        .step       (step_c),
        .elim       (elim_c),
        .pivot      (k),
        .row        (cmd_row),
        .col        (cmd_col),
        .col_last_c (col_last_c),
        .row_last_c (row_last_c)
    );

    // Sequencing FSM; abort overrides everything except reset while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= 2'(OP_NONE);
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (abort && (state != ST_IDLE)) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= 2'(OP_NONE);
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state <= ST_CHECK;
                        k     <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (pivot_zero) begin
                        state <= ST_FIN;
                        err   <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        state     <= ST_NORM;
                        cmd_valid <= 1'b1;
                        cmd_op    <= 2'(OP_NORM);
                    end
                end
                ST_NORM: begin
                    if (hs_c && col_last_c) begin
                        state  <= ST_ELIM;
                        cmd_op <= 2'(OP_ELIM);
                    end
                end
                ST_ELIM: begin
                    if (hs_c && col_last_c && row_last_c) begin
                        cmd_valid <= 1'b0;
                        cmd_op    <= 2'(OP_NONE);
                        if (k == RW'(N - 1)) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_CHECK;
                            k     <= k + RW'(1);
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
